// File: rtl/disp_mux_pkg.sv
// disp_mux_pkg: shared state encoding and active-low segment constants for the display mux
package disp_mux_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] SEL_OFF = 4'hF;
endpackage

// File: rtl/disp_mux_seg7_dec.sv
// seg7_dec: hex nibble to active-low 7-segment pattern (g..a)
module seg7_dec
  import disp_mux_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // table lookup of the shared segment constants
  always_comb begin
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end
endmodule

// File: rtl/disp_mux.sv
// disp_mux: memory-mapped 4-digit multiplexed hex display driver (optional DISP_LZ_BLANK_EN leading-zero blanking)
module disp_mux
  import disp_mux_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel
);
  logic [DATA_W-1:0] value_q;
  logic [3:0]        dp_q;
  state_e            state_q, state_d;
  logic [1:0]        digit_q, digit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        disp_q, disp_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic              lead_zero;

  assign nib      = value_q[{digit_q, 2'b00} +: 4];
  assign data_out = value_q;
  assign Disp     = disp_q;
  assign Disp_sel = sel_q;

  seg7_dec u_dec (.nib_i(nib), .seg_o(seg));

`ifdef DISP_LZ_BLANK_EN
  assign lead_zero = (digit_q != 2'd0) && ((value_q >> {digit_q, 2'b00}) == '0);
`else
  assign lead_zero = 1'b0;
`endif

  // scan sequencing: blank gap, then lit digit, advancing the digit after each lit phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (state_q == BLANK && cnt_q == CNT_W'(BLANK_CYC - 1)) begin
      state_d = SHOW;
      cnt_d   = '0;
    end else if (state_q == SHOW && cnt_q == CNT_W'(SHOW_CYC - 1)) begin
      state_d = BLANK;
      cnt_d   = '0;
      digit_d = digit_q + 1'b1;
    end
  end

  // output pattern for the current state and digit, registered below
  always_comb begin
    disp_d = (state_q == SHOW) ? {~dp_q[digit_q], lead_zero ? SEG_OFF : seg} : {1'b1, SEG_OFF};
    sel_d  = (state_q == SHOW) ? ~(4'b0001 << digit_q) : SEL_OFF;
  end

  // bus registers, scan state and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      dp_q    <= '0;
      state_q <= BLANK;
      digit_q <= '0;
      cnt_q   <= '0;
      disp_q  <= {1'b1, SEG_OFF};
      sel_q   <= SEL_OFF;
    end else begin
      if (sel && we && !addr) value_q <= data_in;
      if (sel && we && addr) dp_q <= data_in[3:0];
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_disp_mux.sv
// tb_disp_mux: randomized and directed checks of disp_mux against a timeline model
module tb_disp_mux;
  localparam int S = 4;
  localparam int B = 2;
  localparam int PER = 4 * (S + B);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, sel = 1'b0, we = 1'b0, addr = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [7:0] Disp;
  logic [3:0] Disp_sel;

  int total = 0;
  int bad = 0;

  disp_mux #(.DATA_W(16), .SHOW_CYC(S), .BLANK_CYC(B), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // timeline model: n posedges since reset select a phase of the refresh period
  function automatic logic [11:0] model(input int n, input logic [15:0] v, input logic [3:0] dp);
    int pos, d, w;
    logic [6:0] sg;
    pos = n % PER;
    d = pos / (S + B);
    w = pos % (S + B);
    if (w < B) return {4'hF, 8'hFF};
    sg = SEG[v[d*4 +: 4]];
    if (LZ && d > 0 && (v >> (4 * d)) == 16'h0) sg = 7'h7F;
    return {~(4'b0001 << d), ~dp[d], sg};
  endfunction

  int m_n = 0;
  logic [15:0] m_v = '0;
  logic [3:0] m_dp = '0;
  logic [11:0] m_out = '0;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0;
      m_v = '0;
      m_dp = '0;
      m_out = {4'hF, 8'hFF};
      m_ok = 1'b1;
    end else if (m_ok) begin
      m_out = model(m_n, m_v, m_dp);
      m_n++;
      if (sel && we && !addr) m_v = data_in;
      if (sel && we && addr) m_dp = data_in[3:0];
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("disp", {8'h0, Disp}, {8'h0, m_out[7:0]});
      chk("disp_sel", {12'h0, Disp_sel}, {12'h0, m_out[11:8]});
      chk("data_out", data_out, m_v);
    end
  end

  task automatic wr(input logic a, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] s);
    for (int i = 0; i < 100 && Disp_sel !== s; i++) @(negedge clk);
    chk("wait_sel", {12'h0, Disp_sel}, {12'h0, s});
  endtask

  initial begin
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_disp", {8'h0, Disp}, 16'h00FF);
    chk("rst_sel", {12'h0, Disp_sel}, 16'h000F);
    chk("rst_data", data_out, 16'h0000);
    @(negedge clk); @(negedge clk);
    chk("pre_first_sel", {12'h0, Disp_sel}, 16'h000F);
    @(negedge clk);
    chk("first_sel", {12'h0, Disp_sel}, 16'h000E);
    chk("first_disp", {8'h0, Disp}, 16'h00C0);
    wr(1'b0, 16'h12AF);
    chk("val_rb", data_out, 16'h12AF);
    wait_sel(4'b1101); chk("scan_d1", {8'h0, Disp}, 16'h0088);
    wait_sel(4'b1011); chk("scan_d2", {8'h0, Disp}, 16'h00A4);
    wait_sel(4'b0111); chk("scan_d3", {8'h0, Disp}, 16'h00F9);
    wait_sel(4'b1110); chk("scan_d0", {8'h0, Disp}, 16'h008E);
    wr(1'b1, 16'h0004);
    wait_sel(4'b1011); chk("dp_d2", {8'h0, Disp}, 16'h0024);
    wait_sel(4'b0111); chk("dp_d3", {8'h0, Disp}, 16'h00F9);
    wait_sel(4'b1110); chk("mid_before", {8'h0, Disp}, 16'h008E);
    sel = 1'b1; we = 1'b1; addr = 1'b0; data_in = 16'h0000;
    @(negedge clk); sel = 1'b0; we = 1'b0;
    chk("mid_hold", {8'h0, Disp}, 16'h008E);
    @(negedge clk);
    chk("mid_new", {8'h0, Disp}, 16'h00C0);
    chk("mid_sel", {12'h0, Disp_sel}, 16'h000E);
    wr(1'b0, 16'h12AF);
    wait_sel(4'b1011);
    rst = 1'b1; sel = 1'b1; we = 1'b1; addr = 1'b0; data_in = 16'hFFFF;
    @(negedge clk); rst = 1'b0; sel = 1'b0; we = 1'b0;
    chk("mrst_disp", {8'h0, Disp}, 16'h00FF);
    chk("mrst_sel", {12'h0, Disp_sel}, 16'h000F);
    chk("mrst_data", data_out, 16'h0000);
    repeat (3) @(negedge clk);
    chk("mrst_restart_sel", {12'h0, Disp_sel}, 16'h000E);
    chk("mrst_restart_disp", {8'h0, Disp}, 16'h00C0);
    wr(1'b0, 16'h0030);
    wait_sel(4'b0111); chk("lz_d3", {8'h0, Disp}, LZ ? 16'h00FF : 16'h00C0);
    wait_sel(4'b1011); chk("lz_d2", {8'h0, Disp}, LZ ? 16'h00FF : 16'h00C0);
    wait_sel(4'b1101); chk("lz_d1", {8'h0, Disp}, 16'h00B0);
    wait_sel(4'b1110); chk("lz_d0", {8'h0, Disp}, 16'h00C0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      sel = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1) == 1;
      addr = $urandom_range(0, 3) == 0;
      data_in = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    end
    @(negedge clk); rst = 1'b0; sel = 1'b0; we = 1'b0;
    repeat (PER) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
